// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Optional macro ICACHE_STAT_EN adds saturating hit/miss counters.
module icache #(
  parameter int unsigned INDEX_WIDTH = 6
) (
`ifdef ICACHE_STAT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_from_fetcher,
  input  logic        en_signal_from_fetcher,
  input  logic        drop_flag_from_fetcher,
  output logic        ok_flag_to_fetcher,
  output logic [31:0] inst_to_fetcher,
  output logic [31:0] pc_to_memctrl,
  output logic        en_signal_to_memctrl,
  input  logic        ok_flag_from_memctrl,
  input  logic [31:0] inst_from_memctrl
);

  localparam int unsigned TAG_WIDTH = 32 - 2 - INDEX_WIDTH;
  localparam int unsigned LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state, state_next;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];
  logic [INDEX_WIDTH-1:0] req_index, lat_index;
  logic [TAG_WIDTH-1:0]   req_tag, lat_tag;
  logic                   hit_c, accept_c, fill_c;
  logic                   unused_pc_bits;

  // Lookup of the incoming PC against the array
  assign req_index      = pc_from_fetcher[INDEX_WIDTH+1:2];
  assign req_tag        = pc_from_fetcher[31:INDEX_WIDTH+2];
  assign hit_c          = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign unused_pc_bits = ^pc_from_fetcher[1:0];

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and strobe decode; drop overrides everything while ready
  always_comb begin
    state_next           = state;
    accept_c             = 1'b0;
    fill_c               = 1'b0;
    ok_flag_to_fetcher   = (state == DONE) && rdy_in && !drop_flag_from_fetcher;
    en_signal_to_memctrl = (state == REQ)  && rdy_in && !drop_flag_from_fetcher;
    if (rdy_in) begin
      if (drop_flag_from_fetcher) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE: if (en_signal_from_fetcher) begin
            accept_c   = 1'b1;
            state_next = hit_c ? DONE : REQ;
          end
          REQ:  state_next = WAIT;
          WAIT: if (ok_flag_from_memctrl) begin
            fill_c     = 1'b1;
            state_next = DONE;
          end
          DONE: state_next = IDLE;
        endcase
      end
    end
  end

  // Valid bits, latched request and registered fetcher/memctrl outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid           <= '0;
      lat_index       <= '0;
      lat_tag         <= '0;
      inst_to_fetcher <= '0;
      pc_to_memctrl   <= '0;
    end else begin
      if (accept_c) begin
        lat_index <= req_index;
        lat_tag   <= req_tag;
        if (hit_c) inst_to_fetcher <= data_mem[req_index];
        else       pc_to_memctrl   <= {pc_from_fetcher[31:2], 2'b00};
      end
      if (fill_c) begin
        valid[lat_index] <= 1'b1;
        inst_to_fetcher  <= inst_from_memctrl;
      end
    end
  end

  // Tag and data arrays, written only on a completed fill
  always_ff @(posedge clk_in) begin
    if (fill_c) begin
      tag_mem[lat_index]  <= lat_tag;
      data_mem[lat_index] <= inst_from_memctrl;
    end
  end

`ifdef ICACHE_STAT_EN
  // Saturating hit/miss counters, bumped at request acceptance
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept_c) begin
      if (hit_c && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (!hit_c && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: vector table of fetches plus drop, ready-stall
// and async-reset sequences.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_from_fetcher;
  logic        en_signal_from_fetcher;
  logic        drop_flag_from_fetcher;
  logic        ok_flag_to_fetcher;
  logic [31:0] inst_to_fetcher;
  logic [31:0] pc_to_memctrl;
  logic        en_signal_to_memctrl;
  logic        ok_flag_from_memctrl;
  logic [31:0] inst_from_memctrl;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] fill;
    logic        miss;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [13];

  icache dut (
`ifdef ICACHE_STAT_EN
    .hit_count              (hit_count),
    .miss_count             (miss_count),
`endif
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .pc_from_fetcher        (pc_from_fetcher),
    .en_signal_from_fetcher (en_signal_from_fetcher),
    .drop_flag_from_fetcher (drop_flag_from_fetcher),
    .ok_flag_to_fetcher     (ok_flag_to_fetcher),
    .inst_to_fetcher        (inst_to_fetcher),
    .pc_to_memctrl          (pc_to_memctrl),
    .en_signal_to_memctrl   (en_signal_to_memctrl),
    .ok_flag_from_memctrl   (ok_flag_from_memctrl),
    .inst_from_memctrl      (inst_from_memctrl)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One fetch: request, optional memctrl fill, completion strobe
  task automatic do_req(input string tag, input logic [31:0] p, input logic [31:0] f,
                        input logic m, input logic [31:0] e);
    @(negedge clk_in);
    chk({tag, ".idle_ok"}, 32'(ok_flag_to_fetcher), 32'd0);
    en_signal_from_fetcher = 1'b1;
    pc_from_fetcher        = p;
    @(negedge clk_in);
    chk({tag, ".mreq"}, 32'(en_signal_to_memctrl), 32'(m));
    if (en_signal_to_memctrl) begin
      chk({tag, ".mpc"}, pc_to_memctrl, {p[31:2], 2'b00});
      chk({tag, ".early_ok"}, 32'(ok_flag_to_fetcher), 32'd0);
      @(negedge clk_in);
      chk({tag, ".mreq_once"}, 32'(en_signal_to_memctrl), 32'd0);
      ok_flag_from_memctrl = 1'b1;
      inst_from_memctrl    = f;
      @(negedge clk_in);
      ok_flag_from_memctrl = 1'b0;
      inst_from_memctrl    = 32'd0;
    end
    chk({tag, ".ok"}, 32'(ok_flag_to_fetcher), 32'd1);
    chk({tag, ".inst"}, inst_to_fetcher, e);
    en_signal_from_fetcher = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1004, 32'h0051_3023, 1'b1, 32'h0051_3023};
    vecs[1]  = '{32'h0000_1004, 32'h0000_0000, 1'b0, 32'h0051_3023};
    vecs[2]  = '{32'h0000_1006, 32'h0000_0000, 1'b0, 32'h0051_3023};
    vecs[3]  = '{32'h0000_1104, 32'h1111_1111, 1'b1, 32'h1111_1111};
    vecs[4]  = '{32'h0000_1004, 32'h0051_3023, 1'b1, 32'h0051_3023};
    vecs[5]  = '{32'h0000_1104, 32'h2222_2222, 1'b1, 32'h2222_2222};
    vecs[6]  = '{32'h0000_0008, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[7]  = '{32'h0000_0008, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{32'h0000_1104, 32'h0000_0000, 1'b0, 32'h2222_2222};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF};
    vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h89AB_CDEF};
    vecs[11] = '{32'h0000_00FC, 32'h0102_0304, 1'b1, 32'h0102_0304};
    vecs[12] = '{32'hFFFF_FFFC, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA};

    rst_in = 1'b0;
    rdy_in = 1'b1;
    pc_from_fetcher        = 32'd0;
    en_signal_from_fetcher = 1'b0;
    drop_flag_from_fetcher = 1'b0;
    ok_flag_from_memctrl   = 1'b0;
    inst_from_memctrl      = 32'd0;
    #3;
    chk("rst.ok",   32'(ok_flag_to_fetcher), 32'd0);
    chk("rst.mreq", 32'(en_signal_to_memctrl), 32'd0);
    chk("rst.inst", inst_to_fetcher, 32'd0);
    chk("rst.mpc",  pc_to_memctrl, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    for (int i = 0; i < 13; i++)
      do_req($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fill, vecs[i].miss, vecs[i].inst);

    // Drop together with fill data in WAIT, then a stray fill in IDLE
    @(negedge clk_in);
    en_signal_from_fetcher = 1'b1;
    pc_from_fetcher        = 32'h0000_2000;
    @(negedge clk_in);
    chk("drop.mreq", 32'(en_signal_to_memctrl), 32'd1);
    @(negedge clk_in);
    en_signal_from_fetcher = 1'b0;
    drop_flag_from_fetcher = 1'b1;
    ok_flag_from_memctrl   = 1'b1;
    inst_from_memctrl      = 32'hDEAD_BEEF;
    #1 chk("drop.ok_masked", 32'(ok_flag_to_fetcher), 32'd0);
    @(negedge clk_in);
    drop_flag_from_fetcher = 1'b0;
    chk("drop.no_ok", 32'(ok_flag_to_fetcher), 32'd0);
    @(negedge clk_in);
    ok_flag_from_memctrl = 1'b0;
    chk("drop.stray_ok", 32'(ok_flag_to_fetcher), 32'd0);
    do_req("drop.refetch", 32'h0000_2000, 32'h0000_0013, 1'b1, 32'h0000_0013);

    // Drop while in REQ suppresses the memctrl strobe
    @(negedge clk_in);
    en_signal_from_fetcher = 1'b1;
    pc_from_fetcher        = 32'h0000_3000;
    @(negedge clk_in);
    drop_flag_from_fetcher = 1'b1;
    en_signal_from_fetcher = 1'b0;
    #1 chk("dropreq.mreq", 32'(en_signal_to_memctrl), 32'd0);
    @(negedge clk_in);
    drop_flag_from_fetcher = 1'b0;
    chk("dropreq.after", 32'(en_signal_to_memctrl), 32'd0);
    do_req("dropreq.refetch", 32'h0000_3000, 32'h0000_3333, 1'b1, 32'h0000_3333);

    // rdy_in low for three cycles in DONE, then exactly one ok pulse
    @(negedge clk_in);
    en_signal_from_fetcher = 1'b1;
    pc_from_fetcher        = 32'h0000_0008;
    @(negedge clk_in);
    rdy_in = 1'b0;
    #1 chk("stall.ok0", 32'(ok_flag_to_fetcher), 32'd0);
    @(negedge clk_in);
    chk("stall.ok1", 32'(ok_flag_to_fetcher), 32'd0);
    @(negedge clk_in);
    chk("stall.ok2", 32'(ok_flag_to_fetcher), 32'd0);
    rdy_in = 1'b1;
    #1 chk("stall.ok", 32'(ok_flag_to_fetcher), 32'd1);
    chk("stall.inst", inst_to_fetcher, 32'hCAFE_F00D);
    en_signal_from_fetcher = 1'b0;
    @(negedge clk_in);
    chk("stall.second_ok", 32'(ok_flag_to_fetcher), 32'd0);
    @(negedge clk_in);
    chk("stall.third_ok", 32'(ok_flag_to_fetcher), 32'd0);

    // Async reset in WAIT clears outputs and the array
    @(negedge clk_in);
    en_signal_from_fetcher = 1'b1;
    pc_from_fetcher        = 32'h0000_4000;
    @(negedge clk_in);
    chk("arst.mreq", 32'(en_signal_to_memctrl), 32'd1);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("arst.ok",   32'(ok_flag_to_fetcher), 32'd0);
    chk("arst.mreq0", 32'(en_signal_to_memctrl), 32'd0);
    chk("arst.inst", inst_to_fetcher, 32'd0);
    chk("arst.mpc",  pc_to_memctrl, 32'd0);
    en_signal_from_fetcher = 1'b0;
    @(negedge clk_in);
    ok_flag_from_memctrl = 1'b1;
    inst_from_memctrl    = 32'h9999_9999;
    @(negedge clk_in);
    ok_flag_from_memctrl = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);
    ok_flag_from_memctrl = 1'b1;
    @(negedge clk_in);
    ok_flag_from_memctrl = 1'b0;
    inst_from_memctrl    = 32'd0;
    chk("arst.stray_ok", 32'(ok_flag_to_fetcher), 32'd0);
    do_req("arst.cached_miss", 32'h0000_0008, 32'h7777_7777, 1'b1, 32'h7777_7777);
    do_req("arst.refetch", 32'h0000_4000, 32'h4444_4444, 1'b1, 32'h4444_4444);

`ifdef ICACHE_STAT_EN
    // Counters: 3 misses then 5 hits from a fresh reset
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("stat.hit0", hit_count, 32'd0);
    chk("stat.miss0", miss_count, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++)
      do_req($sformatf("stat.m%0d", i), 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'hA0 + 32'(i));
    for (int i = 0; i < 5; i++)
      do_req($sformatf("stat.h%0d", i), 32'h100 + 32'(4 * (i % 3)), 32'd0, 1'b0, 32'hA0 + 32'(i % 3));
    chk("stat.hit", hit_count, 32'd5);
    chk("stat.miss", miss_count, 32'd3);
`endif

    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the fetcher and the memory controller.
- Each fetcher request for a 32-bit instruction at a PC is served from the local array on a hit.
- On a miss, the cache issues one 4-byte fetch request to the memory controller and fills the line from the returned word.
- Fetch traffic on the byte-serial RAM port drops to cold misses and conflict misses only.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines, one 32-bit word per line).
- TAG_WIDTH, 32-2-INDEX_WIDTH, tag bits taken from pc[31:INDEX_WIDTH+2]. Derived; must not be overridden.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes the block.
- pc_from_fetcher  input  32  request PC; bits [1:0] ignored.
- en_signal_from_fetcher  input  1  request valid; held high by the fetcher until ok_flag_to_fetcher.
- drop_flag_from_fetcher  input  1  rollback; cancels the outstanding request.
- ok_flag_to_fetcher  output  1  one-cycle completion strobe.
- inst_to_fetcher  output  32  instruction; valid while ok_flag_to_fetcher is high.
- pc_to_memctrl  output  32  word-aligned miss address ({pc[31:2],2'b00}).
- en_signal_to_memctrl  output  1  one-cycle fetch request strobe.
- ok_flag_from_memctrl  input  1  fill-complete strobe.
- inst_from_memctrl  input  32  fill data; valid with ok_flag_from_memctrl.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all valid bits cleared, state IDLE.
  - inst_to_fetcher=0, pc_to_memctrl=0, ok_flag_to_fetcher=0, en_signal_to_memctrl=0.
  - Reset mid-miss abandons the miss; any later ok_flag_from_memctrl is ignored.
- Storage: valid[2^INDEX_WIDTH], tag[TAG_WIDTH], data[32]. Index is pc[INDEX_WIDTH+1:2].
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Request accepted when en_signal_from_fetcher=1, drop_flag_from_fetcher=0 and rdy_in=1. The PC is latched.
  - Hit (valid and tag match): inst_to_fetcher <= data[index], go to DONE.
  - Miss: pc_to_memctrl <= aligned PC, go to REQ.
- REQ: go to WAIT after one rdy-high cycle.
- WAIT:
  - On ok_flag_from_memctrl with no drop: write valid/tag/data at the latched index, inst_to_fetcher <= inst_from_memctrl, go to DONE.
  - ok_flag_from_memctrl received in IDLE, REQ or DONE is ignored.
- DONE: go to IDLE after one rdy-high cycle. en is not sampled in DONE (one-cycle bubble), so the fetcher can advance the PC before the next acceptance.
- Output decode:
  - ok_flag_to_fetcher = (state==DONE) & rdy_in & !drop_flag_from_fetcher.
  - en_signal_to_memctrl = (state==REQ) & rdy_in & !drop_flag_from_fetcher.
- Latency:
  - hit: request accepted at edge T, ok high in cycle T+1.
  - miss: en_to_memctrl high in cycle T+1; ok_to_fetcher high in the cycle after ok_flag_from_memctrl.
- Drop (any state, rdy high): next state IDLE, no strobe that cycle, no fill.
  - Drop together with ok_flag_from_memctrl in WAIT: drop wins, the line is not written.
- rdy_in low: state, array and latched registers hold; both strobes read 0. The pending REQ or DONE strobe is issued on the first rdy-high cycle.
- Exactly one memctrl request per miss; a new request is never issued before the current one completes or is dropped.
- Lines are never invalidated except by reset. The block has no self-modifying-code coherence.

Optional Feature:
- Macro ICACHE_STAT_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - Each counter increments by 1 on an accepted hit or miss respectively, counted even if the request is later dropped.
  - Counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss then hit:
  - Request pc=0x0000_1004; expect en_signal_to_memctrl one cycle later with pc_to_memctrl=0x1004.
  - Memctrl returns 0x0051_3023; expect ok with inst=0x0051_3023 one cycle later.
  - Repeat the request; expect ok at T+1 and no memctrl request.
- Conflict: fill 0x1004 then 0x1104 (same index, INDEX_WIDTH=6); then request 0x1004 -> miss and memctrl request re-issued.
- Drop in WAIT: miss on 0x2000, assert drop, then pulse ok_flag_from_memctrl with 0xDEAD_BEEF -> no ok_to_fetcher; a later request to 0x2000 misses again.
- rdy_in low for 3 cycles while in DONE -> ok stays 0, then exactly one ok pulse once rdy returns; a second ok pulse is a failure.
- Async reset asserted mid-WAIT -> all outputs 0 immediately; a previously cached PC misses after release.
- With ICACHE_STAT_EN: 3 misses then 5 hits -> miss_count=3, hit_count=5.
